conv_tail_framer: RTL and testbench

Upstream input stage for the tail-biting rate-1/3 convolutional encoder. Accepts a block as a byte stream and forwards every byte to the encoder's block-data FIFO. At the end of each block it writes one metadata byte to the block-meta FIFO, carrying the block's last six bits (tail-biting register preload) and the size flag. It also drives the encoder's `blk_ready` level from a count of blocks whose metadata is written but not yet consumed.

---
 rtl/conv_tail_framer.sv | 152 +++++++++++++++
 tb/tb_conv_tail_framer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tail_framer.sv
// Input framer for the tail-biting convolutional encoder: forwards block bytes to the data FIFO,
// then writes a metadata byte (last six bits + size flag) and tracks blocks pending in the encoder.
module conv_tail_framer #(
   parameter int unsigned SMALL_BYTES = 132,
   parameter int unsigned LARGE_BYTES = 768,
   parameter int unsigned MAX_PENDING = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_start,
   input  logic       in_size,
   output logic       in_ready,
   input  logic       data_full,
   output logic       data_wrreq,
   output logic [7:0] data_out,
   input  logic       meta_full,
   output logic       meta_wrreq,
   output logic [7:0] meta_out,
   input  logic       blk_meta_rdreq,
   output logic       blk_ready,
   output logic       framing_err
);

   localparam int unsigned CW = $clog2(LARGE_BYTES + 1);
   localparam int unsigned PW = $clog2(MAX_PENDING + 1);

   typedef enum logic [1:0] {StIdle, StStream, StMeta} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d, count_inc, last_cnt;
   logic          size_q, size_d;
   logic [5:0]    tail_q, tail_d;
   logic          data_wrreq_q, data_wrreq_d;
   logic [7:0]    data_out_q, data_out_d;
   logic          meta_wrreq_q, meta_wrreq_d;
   logic [7:0]    meta_out_q, meta_out_d;
   logic          framing_err_q, framing_err_d;
   logic [PW-1:0] pending_q, pending_d;
   logic [PW:0]   pending_eff;
   logic          accept, pend_inc, pend_dec;

   // A meta write in flight is already committed, so the gate counts it before pending catches up.
   assign pending_eff = {1'b0, pending_q} + {{PW{1'b0}}, meta_wrreq_q};
   assign count_inc   = count_q + CW'(1);
   assign last_cnt    = size_q ? CW'(LARGE_BYTES) : CW'(SMALL_BYTES);
   assign accept      = in_valid && in_ready;

   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         StIdle:   in_ready = !data_full && (pending_eff < (PW+1)'(MAX_PENDING));
         StStream: in_ready = !data_full;
         default:  in_ready = 1'b0;
      endcase
      if (reset) in_ready = 1'b0;
   end

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      size_d        = size_q;
      tail_d        = tail_q;
      data_wrreq_d  = 1'b0;
      data_out_d    = data_out_q;
      meta_wrreq_d  = 1'b0;
      meta_out_d    = meta_out_q;
      framing_err_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (in_start) begin
                  size_d       = in_size;
                  count_d      = CW'(1);
                  data_wrreq_d = 1'b1;
                  data_out_d   = in_data;
                  state_d      = StStream;
               end else begin
                  framing_err_d = 1'b1;
               end
            end
         end
         StStream: begin
            if (accept) begin
               data_wrreq_d  = 1'b1;
               data_out_d    = in_data;
               count_d       = count_inc;
               framing_err_d = in_start;
               if (count_inc == last_cnt) begin
                  tail_d  = in_data[7:2];
                  state_d = StMeta;
               end
            end
         end
         StMeta: begin
            if (!meta_full) begin
               meta_wrreq_d = 1'b1;
               meta_out_d   = {tail_q, 1'b0, size_q};
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign pend_inc = meta_wrreq_q;
   assign pend_dec = blk_meta_rdreq && (pending_q != '0);

   always_comb begin
      pending_d = pending_q;
      if (pend_inc && !pend_dec) begin
         pending_d = pending_q + PW'(1);
      end else if (pend_dec && !pend_inc) begin
         pending_d = pending_q - PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         count_q       <= '0;
         size_q        <= 1'b0;
         tail_q        <= '0;
         data_wrreq_q  <= 1'b0;
         data_out_q    <= '0;
         meta_wrreq_q  <= 1'b0;
         meta_out_q    <= '0;
         framing_err_q <= 1'b0;
         pending_q     <= '0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         size_q        <= size_d;
         tail_q        <= tail_d;
         data_wrreq_q  <= data_wrreq_d;
         data_out_q    <= data_out_d;
         meta_wrreq_q  <= meta_wrreq_d;
         meta_out_q    <= meta_out_d;
         framing_err_q <= framing_err_d;
         pending_q     <= pending_d;
      end
   end

   assign data_wrreq  = data_wrreq_q;
   assign data_out    = data_out_q;
   assign meta_wrreq  = meta_wrreq_q;
   assign meta_out    = meta_out_q;
   assign framing_err = framing_err_q;
   assign blk_ready   = (pending_q != '0);

endmodule

// File: tb/tb_conv_tail_framer.sv
// Scoreboard bench for conv_tail_framer: expected FIFO writes are queued at each accepted byte
// and compared as the DUT emits them; timing and gating are checked directly in the main flow.
module tb_conv_tail_framer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0, in_start = 1'b0, in_size = 1'b0;
   logic       in_ready;
   logic       data_full = 1'b0, meta_full = 1'b0, blk_meta_rdreq = 1'b0;
   logic       data_wrreq, meta_wrreq, blk_ready, framing_err;
   logic [7:0] data_out, meta_out;

   int         n_tests = 0, n_fail = 0;
   int         exp_err = 0, obs_err = 0;
   logic [7:0] data_q[$];
   logic [7:0] meta_q[$];
   logic       bp_en = 1'b0;
   logic       m_in_blk = 1'b0, m_size = 1'b0;
   int         m_cnt = 0;

   conv_tail_framer dut (
      .clk            (clk),
      .reset          (reset),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_start       (in_start),
      .in_size        (in_size),
      .in_ready       (in_ready),
      .data_full      (data_full),
      .data_wrreq     (data_wrreq),
      .data_out       (data_out),
      .meta_full      (meta_full),
      .meta_wrreq     (meta_wrreq),
      .meta_out       (meta_out),
      .blk_meta_rdreq (blk_meta_rdreq),
      .blk_ready      (blk_ready),
      .framing_err    (framing_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (data_wrreq === 1'b1) begin
         check_eq("data_expected", data_q.size() != 0, 1);
         if (data_q.size() != 0) check_eq("data_out", data_out, data_q.pop_front());
      end
      if (meta_wrreq === 1'b1) begin
         check_eq("meta_expected", meta_q.size() != 0, 1);
         if (meta_q.size() != 0) check_eq("meta_out", meta_out, meta_q.pop_front());
      end
      if (framing_err === 1'b1) obs_err++;
   end

   // data_full toggles once per cycle while backpressure is enabled
   always @(posedge clk) if (bp_en) #1 data_full = ~data_full;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model(input logic [7:0] d, input logic st, input logic sz);
      if (!m_in_blk) begin
         if (st) begin
            m_in_blk = 1'b1;
            m_cnt    = 1;
            m_size   = sz;
            data_q.push_back(d);
         end else begin
            exp_err++;
         end
      end else begin
         data_q.push_back(d);
         m_cnt++;
         if (st) exp_err++;
         if (m_cnt == (m_size ? 768 : 132)) begin
            meta_q.push_back({d[7:2], 1'b0, m_size});
            m_in_blk = 1'b0;
         end
      end
   endtask

   // Holds one byte until accepted; returns 1 ns into the cycle after the accepting edge.
   task automatic send(input logic [7:0] d, input logic st, input logic sz);
      int   w = 0;
      logic acc = 1'b0;
      in_data  = d;
      in_start = st;
      in_size  = sz;
      in_valid = 1'b1;
      while (!acc && w < 300) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         w++;
      end
      in_valid = 1'b0;
      in_start = 1'b0;
      check_eq("accept_in_time", acc, 1);
      if (acc) model(d, st, sz);
   endtask

   task automatic send_block(input logic sz, input int n, input int mul, input int add,
                             input int err_at);
      for (int k = 0; k < n; k++) begin
         send(8'(k * mul + add), (k == 0) || (k == err_at), sz);
         if (k == err_at) check_eq("err_mid_block", framing_err, 1);
      end
   endtask

   task automatic rd_pulse();
      blk_meta_rdreq = 1'b1;
      tick();
      blk_meta_rdreq = 1'b0;
   endtask

   initial begin
      tick();
      #1;
      check_eq("rst_in_ready", in_ready, 0);
      tick();
      check_eq("rst_data_wrreq", data_wrreq, 0);
      check_eq("rst_data_out", data_out, 0);
      check_eq("rst_meta_wrreq", meta_wrreq, 0);
      check_eq("rst_meta_out", meta_out, 0);
      check_eq("rst_blk_ready", blk_ready, 0);
      check_eq("rst_framing_err", framing_err, 0);
      reset = 1'b0;
      #1;
      check_eq("idle_in_ready", in_ready, 1);

      // Small block, byte k = k; last byte 0x83 gives meta 0x80.
      send_block(1'b0, 132, 1, 0, -1);
      check_eq("n1_meta_wrreq", meta_wrreq, 0);
      check_eq("n1_in_ready", in_ready, 0);
      check_eq("n1_blk_ready", blk_ready, 0);
      tick();
      check_eq("n2_meta_wrreq", meta_wrreq, 1);
      check_eq("n2_meta_out", meta_out, 8'h80);
      check_eq("n2_blk_ready", blk_ready, 0);
      tick();
      check_eq("n3_blk_ready", blk_ready, 1);
      rd_pulse();
      check_eq("small_rd_blk_ready", blk_ready, 0);

      // Large block, last byte 0xFF gives meta 0xFD.
      send_block(1'b1, 768, 1, 0, -1);
      tick();
      check_eq("large_meta_out", meta_out, 8'hFD);
      tick();
      check_eq("large_blk_ready", blk_ready, 1);
      rd_pulse();
      check_eq("large_rd_blk_ready", blk_ready, 0);

      // Backpressure on both FIFOs.
      bp_en = 1'b1;
      for (int k = 0; k < 131; k++) send(8'(k * 5 + 7), k == 0, 1'b0);
      meta_full = 1'b1;
      send(8'(131 * 5 + 7), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         check_eq("bp_meta_held", meta_wrreq, 0);
         check_eq("bp_in_ready_meta", in_ready, 0);
         tick();
      end
      bp_en = 1'b0;
      tick();
      tick();
      data_full = 1'b0;
      meta_full = 1'b0;
      begin
         int   w = 0;
         logic seen = 1'b0;
         while (!seen && w < 5) begin
            tick();
            seen = meta_wrreq;
            w++;
         end
         check_eq("bp_meta_released", seen, 1);
      end
      tick();
      tick();
      rd_pulse();
      check_eq("bp_rd_blk_ready", blk_ready, 0);

      // Pending limit: four blocks without reads close the gate.
      for (int b = 0; b < 4; b++) send_block(1'b0, 132, 3, b, -1);
      tick();
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         check_eq("pend_gate_closed", in_ready, 0);
         tick();
      end
      rd_pulse();
      check_eq("pend_gate_open", in_ready, 1);
      send_block(1'b0, 132, 1, 9, -1);
      tick();
      check_eq("pend_meta_wrreq", meta_wrreq, 1);
      rd_pulse();  // coincides with the meta write: pending stays at 3
      rd_pulse();
      rd_pulse();
      check_eq("pend_keep", blk_ready, 1);
      rd_pulse();
      check_eq("pend_empty", blk_ready, 0);
      rd_pulse();
      check_eq("rd_at_zero", blk_ready, 0);

      // Framing errors.
      send(8'hAA, 1'b0, 1'b0);
      check_eq("err_idle", framing_err, 1);
      check_eq("err_idle_nowr", data_wrreq, 0);
      tick();
      check_eq("err_one_cycle", framing_err, 0);
      send_block(1'b0, 132, 2, 1, 49);
      tick();
      tick();
      check_eq("err_blk_ready", blk_ready, 1);

      // Reset mid-block with one block pending.
      for (int k = 0; k < 60; k++) send(8'(k + 100), k == 0, 1'b0);
      reset = 1'b1;
      #1;
      check_eq("rst2_in_ready", in_ready, 0);
      tick();
      check_eq("rst2_data_wrreq", data_wrreq, 0);
      check_eq("rst2_data_out", data_out, 0);
      check_eq("rst2_meta_wrreq", meta_wrreq, 0);
      check_eq("rst2_meta_out", meta_out, 0);
      check_eq("rst2_blk_ready", blk_ready, 0);
      check_eq("rst2_framing_err", framing_err, 0);
      reset    = 1'b0;
      m_in_blk = 1'b0;
      send_block(1'b0, 132, 7, 3, -1);
      tick();
      check_eq("post_rst_meta_wrreq", meta_wrreq, 1);
      tick();
      check_eq("post_rst_blk_ready", blk_ready, 1);

      tick();
      tick();
      check_eq("data_q_drained", data_q.size(), 0);
      check_eq("meta_q_drained", meta_q.size(), 0);
      check_eq("framing_err_count", obs_err, exp_err);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
